// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO read scheduler.
// Holds state encoding and default widths.
package fifo_sched_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int TO_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        WAIT    = 3'd4
    } state_t;

endpackage

// File: rtl/idle_timer.sv
// Saturating idle timer with synchronous clear.
// eq flags that the count has reached the limit.
module idle_timer
    import fifo_sched_pkg::*;
#(
    parameter int W = TO_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         eq
);

    logic [W-1:0] count;

    // Count up while enabled, hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign eq = (count == limit);

endmodule

// File: rtl/fifo_rd_sched.sv
// Burst read scheduler between a FIFO and a
// valid/ready byte consumer, with idle flush.
module fifo_rd_sched
    import fifo_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int TO_W   = TO_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [TO_W-1:0]   timeout,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_flush,
    output logic              busy
);

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_inc;
    logic [TO_W-1:0]   to_q;
    logic              timer_clr;
    logic              timer_en;
    logic              timer_eq;

    assign cnt_inc   = cnt + LEN_W'(1);
    assign timer_clr = (state != WAIT);
    assign timer_en  = (state == WAIT);

    idle_timer #(
        .W (TO_W)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clr),
        .en    (timer_en),
        .limit (to_q),
        .eq    (timer_eq)
    );

    // Burst FSM; every output is a register set on the transition
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            to_q      <= '0;
            cnt       <= '0;
            fifo_rd   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_flush <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fifo_rd   <= 1'b0;
            out_flush <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && !fifo_empty) begin
                        state   <= READ;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        to_q    <= timeout;
                        len_q   <= (burst_len == '0) ?
                                   LEN_W'(1) : burst_len;
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    out_data  <= fifo_data;
                    cnt       <= cnt_inc;
                    out_valid <= 1'b1;
                    out_last  <= (cnt_inc == len_q);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (cnt == len_q) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (!fifo_empty) begin
                            state   <= READ;
                            fifo_rd <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!fifo_empty) begin
                        state   <= READ;
                        fifo_rd <= 1'b1;
                    end else if (timer_eq) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_flush <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: FIFO model, stream
// monitor and per-scenario checks vs a burst model.
module tb_fifo_rd_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  burst_len = '0;
    logic [15:0] timeout = '0;
    logic        fifo_empty;
    logic [7:0]  fifo_data = '0;
    logic        fifo_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        out_flush;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_sched dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .burst_len  (burst_len),
        .timeout    (timeout),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_flush  (out_flush),
        .busy       (busy)
    );

    // FIFO model: data valid the cycle after fifo_rd
    logic [7:0] mem [0:1023];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rp];
            rp <= rp + 1;
        end
    end

    // Stream monitor and protocol watcher
    logic [7:0] got_d [0:511];
    bit         got_l [0:511];
    int cyc = 0, gcnt = 0, fcnt = 0, rcnt = 0, perr = 0;
    int hs_cyc = 0, fl_cyc = 0, rd_cyc = 0;
    logic pv = 1'b0, pr = 1'b0, prd = 1'b0;
    logic [7:0] pd = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) rcnt <= rcnt + 1;
        if (out_flush) begin
            fcnt <= fcnt + 1;
            fl_cyc <= cyc;
        end
        if (out_valid && out_ready && gcnt < 512) begin
            got_d[gcnt] <= out_data;
            got_l[gcnt] <= out_last;
            gcnt <= gcnt + 1;
            hs_cyc <= cyc;
        end
        if (reset) begin
            if (fifo_rd) rd_cyc <= cyc;
            if ((fifo_rd && fifo_empty) ||
                (fifo_rd && (out_valid || prd)) ||
                (out_valid && !pv && (cyc - rd_cyc != 2)) ||
                (pv && !pr && (!out_valid || out_data != pd)) ||
                (out_last && !out_valid))
                perr <= perr + 1;
        end
        pv  <= out_valid & reset;
        pd  <= out_data;
        pr  <= out_ready;
        prd <= fifo_rd;
    end

    // Reference: position inside a burst decides out_last
    function automatic bit exp_last(input int i, input int l);
        int le;
        le = (l == 0) ? 1 : l;
        return (i % le) == (le - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp] = d;
        wp = wp + 1;
    endtask

    // Enable and run until FIFO drained and DUT idle
    task automatic run(input int maxc, input bit rnd,
                       output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        en = 1'b1;
        for (int c = 0; c < maxc; c++) begin
            tick();
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (wp == rp && !busy && !out_valid) quiet++;
            else quiet = 0;
            if (quiet == 3) begin
                ok = 1'b1;
                break;
            end
        end
        en = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL rst_fifo_rd got %b exp 0", fifo_rd);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_last got %b exp 0", out_last);
        end
        checks++;
        if (out_flush !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_flush got %b exp 0", out_flush);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b exp 0", busy);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_out_data got %h exp 00", out_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int g0, f0, p0;
        bit ok;
        logic [7:0] e;
        g0 = gcnt; f0 = fcnt; p0 = perr;
        burst_len = 8'd4;
        timeout = 16'd5;
        for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
        run(300, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got timeout exp idle");
        end
        checks++;
        if ((gcnt - g0) !== 4) begin
            errors++;
            $display("FAIL basic_count got %0d exp 4", gcnt - g0);
        end
        for (int i = 0; i < 4; i++) begin
            e = 8'(8'h11 + i);
            checks++;
            if (got_d[g0+i] !== e ||
                got_l[g0+i] !== exp_last(i, 4)) begin
                errors++;
                $display("FAIL basic_byte%0d got %h/%b exp %h/%b",
                         i, got_d[g0+i], got_l[g0+i], e,
                         exp_last(i, 4));
            end
        end
        checks++;
        if ((fcnt - f0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got flush %0d busy %b exp 0 0",
                     fcnt - f0, busy);
        end
        checks++;
        if ((perr - p0) !== 0) begin
            errors++;
            $display("FAIL basic_proto got %0d exp 0", perr - p0);
        end
    endtask

    task automatic test_two_bursts();
        int g0, f0, p0, r0;
        bit ok;
        logic [7:0] e;
        g0 = gcnt; f0 = fcnt; p0 = perr; r0 = rcnt;
        burst_len = 8'd3;
        timeout = 16'd4;
        for (int i = 0; i < 6; i++) push(8'(8'h21 + i));
        run(300, 1'b0, ok);
        checks++;
        if (!ok || (gcnt - g0) !== 6 || (rcnt - r0) !== 6) begin
            errors++;
            $display("FAIL two_count got %0d bytes %0d reads exp 6 6",
                     gcnt - g0, rcnt - r0);
        end
        for (int i = 0; i < 6; i++) begin
            e = 8'(8'h21 + i);
            checks++;
            if (got_d[g0+i] !== e ||
                got_l[g0+i] !== exp_last(i, 3)) begin
                errors++;
                $display("FAIL two_byte%0d got %h/%b exp %h/%b",
                         i, got_d[g0+i], got_l[g0+i], e,
                         exp_last(i, 3));
            end
        end
        checks++;
        if ((fcnt - f0) !== 0 || (perr - p0) !== 0) begin
            errors++;
            $display("FAIL two_misc got flush %0d proto %0d exp 0 0",
                     fcnt - f0, perr - p0);
        end
    endtask

    task automatic test_stall();
        int g0, r0, p0, n;
        bit ok;
        logic [7:0] d;
        g0 = gcnt; p0 = perr;
        burst_len = 8'd4;
        timeout = 16'd20;
        for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
        en = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (gcnt != g0 + 1 && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        d = out_data;
        r0 = rcnt;
        checks++;
        if (d !== 8'h32 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_byte got %h/%b exp 32/0",
                     d, out_last);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== d) begin
                errors++;
                $display("FAIL stall_hold%0d got %b/%h exp 1/%h",
                         i, out_valid, out_data, d);
            end
        end
        checks++;
        if (rcnt !== r0 || gcnt !== g0 + 1) begin
            errors++;
            $display("FAIL stall_idle got rd %0d hs %0d exp %0d %0d",
                     rcnt, gcnt, r0, g0 + 1);
        end
        run(300, 1'b0, ok);
        checks++;
        if (!ok || (gcnt - g0) !== 4 || got_d[g0+3] !== 8'h34 ||
            got_l[g0+2] !== 1'b0 || got_l[g0+3] !== 1'b1) begin
            errors++;
            $display("FAIL stall_tail got %0d bytes last %h/%b exp 4 34/1",
                     gcnt - g0, got_d[g0+3], got_l[g0+3]);
        end
        checks++;
        if ((perr - p0) !== 0) begin
            errors++;
            $display("FAIL stall_proto got %0d exp 0", perr - p0);
        end
    endtask

    task automatic test_timeout();
        int g0, f0, n;
        g0 = gcnt; f0 = fcnt;
        burst_len = 8'd4;
        timeout = 16'd10;
        push(8'h41);
        push(8'h42);
        en = 1'b1;
        n = 0;
        while (fcnt == f0 && n < 100) begin
            tick();
            n++;
        end
        repeat (5) tick();
        en = 1'b0;
        checks++;
        if ((fcnt - f0) !== 1) begin
            errors++;
            $display("FAIL tmo_flushes got %0d exp 1", fcnt - f0);
        end
        checks++;
        if ((fl_cyc - hs_cyc) !== 12) begin
            errors++;
            $display("FAIL tmo_delay got %0d exp 12", fl_cyc - hs_cyc);
        end
        checks++;
        if ((gcnt - g0) !== 2 || got_l[g0+1] !== 1'b0 ||
            got_d[g0+1] !== 8'h42 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_bytes got %0d %h/%b busy %b exp 2 42/0 0",
                     gcnt - g0, got_d[g0+1], got_l[g0+1], busy);
        end
    endtask

    task automatic test_resume();
        int g0, f0, n;
        bit ok;
        g0 = gcnt; f0 = fcnt;
        burst_len = 8'd4;
        timeout = 16'd10;
        push(8'h51);
        push(8'h52);
        en = 1'b1;
        n = 0;
        while (gcnt != g0 + 2 && n < 50) begin
            tick();
            n++;
        end
        repeat (4) tick();
        push(8'h53);
        push(8'h54);
        run(300, 1'b0, ok);
        checks++;
        if (!ok || (fcnt - f0) !== 0) begin
            errors++;
            $display("FAIL resume_flush got %0d exp 0", fcnt - f0);
        end
        checks++;
        if ((gcnt - g0) !== 4 || got_d[g0+2] !== 8'h53 ||
            got_d[g0+3] !== 8'h54 || got_l[g0+2] !== 1'b0 ||
            got_l[g0+3] !== 1'b1) begin
            errors++;
            $display("FAIL resume_bytes got %0d %h/%b exp 4 54/1",
                     gcnt - g0, got_d[g0+3], got_l[g0+3]);
        end
    endtask

    task automatic test_len0_to0();
        int g0, f0;
        bit ok;
        g0 = gcnt; f0 = fcnt;
        burst_len = 8'd0;
        timeout = 16'd3;
        for (int i = 0; i < 3; i++) push(8'(8'h61 + i));
        run(300, 1'b0, ok);
        checks++;
        if (!ok || (gcnt - g0) !== 3 || (fcnt - f0) !== 0) begin
            errors++;
            $display("FAIL len0_count got %0d/%0d exp 3/0",
                     gcnt - g0, fcnt - f0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_l[g0+i] !== 1'b1 ||
                got_d[g0+i] !== 8'(8'h61 + i)) begin
                errors++;
                $display("FAIL len0_byte%0d got %h/%b exp %h/1",
                         i, got_d[g0+i], got_l[g0+i], 8'h61 + i);
            end
        end
        g0 = gcnt; f0 = fcnt;
        burst_len = 8'd3;
        timeout = 16'd0;
        push(8'h71);
        run(300, 1'b0, ok);
        checks++;
        if (!ok || (gcnt - g0) !== 1 || (fcnt - f0) !== 1 ||
            got_l[g0] !== 1'b0) begin
            errors++;
            $display("FAIL to0_result got %0d/%0d/%b exp 1/1/0",
                     gcnt - g0, fcnt - f0, got_l[g0]);
        end
        checks++;
        if ((fl_cyc - hs_cyc) !== 2) begin
            errors++;
            $display("FAIL to0_delay got %0d exp 2", fl_cyc - hs_cyc);
        end
    endtask

    task automatic test_random();
        int g0, f0, p0, n, l, le, ef;
        bit ok;
        logic [7:0] d [0:11];
        for (int it = 0; it < 8; it++) begin
            g0 = gcnt; f0 = fcnt; p0 = perr;
            n = $urandom_range(1, 12);
            l = $urandom_range(0, 5);
            le = (l == 0) ? 1 : l;
            ef = ((n % le) != 0) ? 1 : 0;
            burst_len = 8'(l);
            timeout = 16'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) begin
                d[i] = 8'($urandom);
                push(d[i]);
            end
            run(2000, 1'b1, ok);
            checks++;
            if (!ok || (gcnt - g0) !== n || (fcnt - f0) !== ef) begin
                errors++;
                $display("FAIL rnd%0d_count got %0d/%0d exp %0d/%0d",
                         it, gcnt - g0, fcnt - f0, n, ef);
            end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got_d[g0+i] !== d[i] ||
                    got_l[g0+i] !== exp_last(i, l)) begin
                    errors++;
                    $display("FAIL rnd%0d_byte%0d got %h/%b exp %h/%b",
                             it, i, got_d[g0+i], got_l[g0+i], d[i],
                             exp_last(i, l));
                end
            end
            checks++;
            if ((perr - p0) !== 0) begin
                errors++;
                $display("FAIL rnd%0d_proto got %0d exp 0",
                         it, perr - p0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g0, f0, n;
        burst_len = 8'd2;
        timeout = 16'd5;
        push(8'h81);
        push(8'h82);
        out_ready = 1'b0;
        en = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        g0 = gcnt; f0 = fcnt;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_send got %b exp 1", out_valid);
        end
        reset = 1'b0;
        en = 1'b0;
        tick();
        checks++;
        if ({fifo_rd, out_valid, out_last, out_flush, busy}
            !== 5'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL rmid_outs got %b%b%b%b%b/%h exp 00000/00",
                     fifo_rd, out_valid, out_last, out_flush, busy,
                     out_data);
        end
        reset = 1'b1;
        repeat (15) tick();
        checks++;
        if (gcnt !== g0 || fcnt !== f0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_quiet got hs %0d fl %0d exp %0d %0d",
                     gcnt, fcnt, g0, f0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_bursts();
        test_stall();
        test_timeout();
        test_resume();
        test_len0_to0();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_sched.md
FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
REQ-001 SHALL have parameter DATA_W, 8, byte width of FIFO data path.
REQ-002 SHALL have parameter LEN_W, 8, width of burst length and byte counter.
REQ-003 SHALL have parameter TO_W, 16, width of idle-timeout value and timer.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port en  in  1  scheduler enable, sampled only in IDLE.
REQ-007 SHALL have port burst_len  in  LEN_W  bytes per burst, sampled at burst start.
REQ-008 SHALL have port timeout  in  TO_W  idle cycles tolerated mid-burst, sampled at burst start.
REQ-009 SHALL have port fifo_empty  in  1  FIFO EMPTY flag.
REQ-010 SHALL have port fifo_data  in  DATA_W  FIFO dataOut, valid the cycle after fifo_rd.
REQ-011 SHALL have port fifo_rd  out  1  FIFO read strobe, single-cycle pulse.
REQ-012 SHALL have port out_data  out  DATA_W  byte presented to consumer.
REQ-013 SHALL have port out_valid  out  1  out_data valid.
REQ-014 SHALL have port out_ready  in  1  consumer accepts byte when high with out_valid.
REQ-015 SHALL have port out_last  out  1  high with out_valid on final byte of full-length burst.
REQ-016 SHALL have port out_flush  out  1  one-cycle pulse ending a short burst on timeout.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, READ, CAPTURE, SEND, WAIT.
REQ-019 IDLE -> READ SHALL occur when en=1 and fifo_empty=0; burst_len, timeout latched; byte counter cleared.
REQ-020 A latched burst_len of 0 SHALL be treated as 1.
REQ-021 READ SHALL assert fifo_rd for exactly one cycle, then go to CAPTURE.
REQ-022 fifo_rd SHALL never be asserted while fifo_empty=1.
REQ-023 CAPTURE SHALL register fifo_data into out_data, increment byte counter, go to SEND.
REQ-024 SEND SHALL hold out_valid=1 and out_data stable until the cycle out_ready=1.
REQ-025 out_last SHALL be 1 in SEND iff byte counter equals latched burst length.
REQ-026 On SEND handshake: if last byte -> IDLE; else if fifo_empty=0 -> READ; else -> WAIT with timer cleared.
REQ-027 Latency fifo_rd to out_valid SHALL be 2 cycles; at most one outstanding FIFO read at any time.
REQ-028 WAIT SHALL increment timer each cycle; fifo_empty=0 -> READ with timer cleared.
REQ-029 WAIT with fifo_empty=1 and timer == latched timeout SHALL pulse out_flush for one cycle and go to IDLE.
REQ-030 Latched timeout of 0 SHALL flush on the first WAIT cycle.
REQ-031 Timer SHALL saturate, never wrap; byte counter SHALL never exceed latched burst length.
REQ-032 Deasserting en mid-burst SHALL not affect the current burst.

Reset
REQ-033 With reset=0 at a rising edge, FSM SHALL enter IDLE, counters and timer clear to 0.
REQ-034 Reset values SHALL be fifo_rd=0, out_valid=0, out_last=0, out_flush=0, busy=0, out_data=0.
REQ-035 Reset mid-burst SHALL discard any held byte without a handshake and without out_flush.

Structure
REQ-036 State encoding and DATA_W/LEN_W/TO_W defaults SHALL reside in shared package fifo_sched_pkg.
REQ-037 Idle timer SHALL be sub-module idle_timer (clear, enable, saturating count, compare-equal output).
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 FIFO preloaded with 4 bytes 0x11..0x14, burst_len=4, out_ready=1 -> 4 bytes in order, out_last only on 0x14, then IDLE.
REQ-040 6 bytes, burst_len=3 -> two bursts of 3, out_last on 3rd and 6th byte, never fifo_rd while empty.
REQ-041 out_ready low 5 cycles on byte 2 -> out_data/out_valid stable, no extra fifo_rd, byte count unchanged.
REQ-042 2 bytes, burst_len=4, timeout=10, no more writes -> WAIT 10 cycles, one out_flush pulse, IDLE; byte 3 written at WAIT cycle 5 -> burst resumes, no flush.
REQ-043 burst_len=0 -> single-byte bursts with out_last each; timeout=0 -> flush on first WAIT cycle.
REQ-044 reset=0 during SEND -> next cycle all outputs 0, IDLE, no handshake or flush observed.
